// File: rtl/reg_cmd_pkg.sv
// Shared types and opcodes for the UART command front-end of the register file.
// Holds the command FSM state encoding and the frame opcodes.
package reg_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ADDR = 3'd1,
        WR_DATA = 3'd2,
        RD_ADDR = 3'd3,
        RD_WAIT = 3'd4,
        TX_WAIT = 3'd5
    } state_t;

    localparam logic [7:0] WR_CMD = 8'hAA;
    localparam logic [7:0] RD_CMD = 8'hBB;

endpackage

// File: rtl/reg_cmd_ctrl.sv
// Turns UART byte frames into single-cycle register-file writes/reads and returns read data to the UART TX.
// Latency: data/addr byte -> WrEn/RdEn next cycle; RdData_Valid -> TX_D_VLD two cycles later. Waits on TX_Busy.
module reg_cmd_ctrl #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 16,
    parameter logic [WIDTH-1:0] WR_CMD  = reg_cmd_pkg::WR_CMD,
    parameter logic [WIDTH-1:0] RD_CMD  = reg_cmd_pkg::RD_CMD,
    parameter int               TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       RST_n,
    input  logic [WIDTH-1:0]           RX_P_DATA,
    input  logic                       RX_D_VLD,
    input  logic [WIDTH-1:0]           RdData,
    input  logic                       RdData_Valid,
    input  logic                       TX_Busy,
    output logic                       WrEn,
    output logic                       RdEn,
    output logic [$clog2(DEPTH)-1:0]   Address,
    output logic [WIDTH-1:0]           WrData,
    output logic [WIDTH-1:0]           TX_P_DATA,
    output logic                       TX_D_VLD,
    output logic                       Cmd_Err
);
    import reg_cmd_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [ADDR_W-1:0]  addr_nxt;
    logic [WIDTH-1:0]   wr_data_nxt;
    logic [WIDTH-1:0]   tx_data_nxt;
    logic               wr_en_nxt;
    logic               rd_en_nxt;
    logic               tx_vld_nxt;
    logic               err_nxt;
    logic               addr_bad;

    // Only the low ADDR_W bits select a register; anything above must be zero.
    assign addr_bad = (RX_P_DATA >> ADDR_W) != '0;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state     <= IDLE;
            cnt       <= '0;
            Address   <= '0;
            WrData    <= '0;
            TX_P_DATA <= '0;
            WrEn      <= 1'b0;
            RdEn      <= 1'b0;
            TX_D_VLD  <= 1'b0;
            Cmd_Err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            Address   <= addr_nxt;
            WrData    <= wr_data_nxt;
            TX_P_DATA <= tx_data_nxt;
            WrEn      <= wr_en_nxt;
            RdEn      <= rd_en_nxt;
            TX_D_VLD  <= tx_vld_nxt;
            Cmd_Err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        addr_nxt    = Address;
        wr_data_nxt = WrData;
        tx_data_nxt = TX_P_DATA;
        wr_en_nxt   = 1'b0;
        rd_en_nxt   = 1'b0;
        tx_vld_nxt  = 1'b0;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                if (RX_D_VLD) begin
                    if (RX_P_DATA == WR_CMD) begin
                        state_nxt = WR_ADDR;
                    end else if (RX_P_DATA == RD_CMD) begin
                        state_nxt = RD_ADDR;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end

            WR_ADDR, RD_ADDR: begin
                if (RX_D_VLD) begin
                    if (addr_bad) begin
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt = RX_P_DATA[ADDR_W-1:0];
                        if (state == WR_ADDR) begin
                            state_nxt = WR_DATA;
                        end else begin
                            rd_en_nxt = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = RD_WAIT;
                        end
                    end
                end
            end

            WR_DATA: begin
                if (RX_D_VLD) begin
                    wr_data_nxt = RX_P_DATA;
                    wr_en_nxt   = 1'b1;
                    state_nxt   = IDLE;
                end
            end

            // Incoming RX bytes are dropped here and in TX_WAIT.
            RD_WAIT: begin
                if (RdData_Valid) begin
                    tx_data_nxt = RdData;
                    state_nxt   = TX_WAIT;
                end else if (cnt >= CNT_LAST) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end

            TX_WAIT: begin
                if (!TX_Busy) begin
                    tx_vld_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Directed bench for reg_cmd_ctrl: vector table for frames, hand sequences for busy, timeout and reset.
module tb_reg_cmd_ctrl;
    localparam int TIMEOUT = 16;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic [7:0] RdData;
    logic       RdData_Valid;
    logic       TX_Busy;
    logic       WrEn, RdEn, TX_D_VLD, Cmd_Err;
    logic [3:0] Address;
    logic [7:0] WrData, TX_P_DATA;

    reg_cmd_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .Cmd_Err(Cmd_Err)
    );

    always #5 CLK = ~CLK;

    // {WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err}
    wire [23:0] obs = {WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err};

    typedef struct {
        string      name;
        logic       rxv;
        logic [7:0] rxd;
        logic       rdv;
        logic [7:0] rdd;
        logic       busy;
        logic [23:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [23:0] ex(input logic wr, input logic rd, input logic [3:0] a,
                                       input logic [7:0] wd, input logic [7:0] td,
                                       input logic tv, input logic er);
        return {wr, rd, a, wd, td, tv, er};
    endfunction

    function automatic vec_t mk(input string n, input logic rxv, input logic [7:0] rxd,
                                input logic rdv, input logic [7:0] rdd, input logic busy,
                                input logic [23:0] e);
        vec_t v;
        v.name = n; v.rxv = rxv; v.rxd = rxd; v.rdv = rdv; v.rdd = rdd; v.busy = busy; v.exp = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1ns after the rising edge.
    task automatic step(input logic rxv, input logic [7:0] rxd, input logic rdv,
                        input logic [7:0] rdd, input logic busy);
        @(negedge CLK);
        RX_D_VLD = rxv; RX_P_DATA = rxd; RdData_Valid = rdv; RdData = rdd; TX_Busy = busy;
        @(posedge CLK);
        #1;
        check("wr_rd_exclusive", {31'd0, WrEn & RdEn}, 32'd0);
    endtask

    task automatic idle(input logic busy);
        step(1'b0, 8'h00, 1'b0, 8'h00, busy);
    endtask

    task automatic rx(input logic [7:0] b);
        step(1'b1, b, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int  k;
        logic tv_seen, en_seen;

        RST_n = 1'b0; RX_D_VLD = 1'b0; RX_P_DATA = '0;
        RdData_Valid = 1'b0; RdData = '0; TX_Busy = 1'b0;

        tbl.push_back(mk("wr_op",       1, 8'hAA, 0, 8'h00, 0, ex(0,0,4'h0,8'h00,8'h00,0,0)));
        tbl.push_back(mk("wr_addr",     1, 8'h07, 0, 8'h00, 0, ex(0,0,4'h7,8'h00,8'h00,0,0)));
        tbl.push_back(mk("wr_data",     1, 8'h46, 0, 8'h00, 0, ex(1,0,4'h7,8'h46,8'h00,0,0)));
        tbl.push_back(mk("wr_after",    0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h00,0,0)));
        tbl.push_back(mk("rd_op",       1, 8'hBB, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h00,0,0)));
        tbl.push_back(mk("rd_addr",     1, 8'h07, 0, 8'h00, 0, ex(0,1,4'h7,8'h46,8'h00,0,0)));
        tbl.push_back(mk("rd_valid",    0, 8'h00, 1, 8'h46, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("tx_strobe",   0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,1,0)));
        tbl.push_back(mk("tx_after",    0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("rdv_in_idle", 0, 8'h00, 1, 8'hFF, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("bad_op",      1, 8'h55, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,1)));
        tbl.push_back(mk("bad_op_end",  0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("badaddr_op",  1, 8'hAA, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("badaddr",     1, 8'h25, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,1)));
        tbl.push_back(mk("badaddr_end", 0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("wr2_op",      1, 8'hAA, 0, 8'h00, 0, ex(0,0,4'h7,8'h46,8'h46,0,0)));
        tbl.push_back(mk("wr2_addr",    1, 8'h01, 0, 8'h00, 0, ex(0,0,4'h1,8'h46,8'h46,0,0)));
        tbl.push_back(mk("wr2_data",    1, 8'h3C, 0, 8'h00, 0, ex(1,0,4'h1,8'h3C,8'h46,0,0)));
        tbl.push_back(mk("wr2_after",   0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h1,8'h3C,8'h46,0,0)));
        tbl.push_back(mk("wr_ro_op",    1, 8'hAA, 0, 8'h00, 0, ex(0,0,4'h1,8'h3C,8'h46,0,0)));
        tbl.push_back(mk("wr_ro_addr",  1, 8'h02, 0, 8'h00, 0, ex(0,0,4'h2,8'h3C,8'h46,0,0)));
        tbl.push_back(mk("wr_ro_data",  1, 8'h99, 0, 8'h00, 0, ex(1,0,4'h2,8'h99,8'h46,0,0)));
        tbl.push_back(mk("wr_ro_after", 0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h2,8'h99,8'h46,0,0)));
        tbl.push_back(mk("rd_bad_op",   1, 8'hBB, 0, 8'h00, 0, ex(0,0,4'h2,8'h99,8'h46,0,0)));
        tbl.push_back(mk("rd_bad_addr", 1, 8'h10, 0, 8'h00, 0, ex(0,0,4'h2,8'h99,8'h46,0,1)));
        tbl.push_back(mk("rd_bad_end",  0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h2,8'h99,8'h46,0,0)));
        tbl.push_back(mk("rd3_op",      1, 8'hBB, 0, 8'h00, 0, ex(0,0,4'h2,8'h99,8'h46,0,0)));
        tbl.push_back(mk("rd3_addr",    1, 8'h04, 0, 8'h00, 0, ex(0,1,4'h4,8'h99,8'h46,0,0)));
        tbl.push_back(mk("rx_in_rdwait",1, 8'hAA, 0, 8'h00, 0, ex(0,0,4'h4,8'h99,8'h46,0,0)));
        tbl.push_back(mk("rd3_valid",   0, 8'h00, 1, 8'hC3, 0, ex(0,0,4'h4,8'h99,8'hC3,0,0)));
        tbl.push_back(mk("rx_in_txwait",1, 8'h55, 0, 8'h00, 0, ex(0,0,4'h4,8'h99,8'hC3,1,0)));
        tbl.push_back(mk("rd3_after",   0, 8'h00, 0, 8'h00, 0, ex(0,0,4'h4,8'h99,8'hC3,0,0)));

        #1;
        check("reset_outputs", {8'd0, obs}, 32'd0);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].rxv, tbl[i].rxd, tbl[i].rdv, tbl[i].rdd, tbl[i].busy);
            check(tbl[i].name, {8'd0, obs}, {8'd0, tbl[i].exp});
        end

        // Read with the transmitter busy for 20 cycles after the data returns.
        rx(8'hBB);
        rx(8'h0E);
        check("busy_rden", {30'd0, RdEn, WrEn}, 32'd2);
        check("busy_addr", {28'd0, Address}, 32'hE);
        step(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1);
        check("busy_txdata", {24'd0, TX_P_DATA}, 32'h5A);
        for (int i = 0; i < 20; i++) begin
            idle(1'b1);
            check("busy_hold_txvld", {31'd0, TX_D_VLD}, 32'd0);
        end
        check("busy_hold_txdata", {24'd0, TX_P_DATA}, 32'h5A);
        idle(1'b0);
        check("busy_release", {23'd0, TX_D_VLD, TX_P_DATA}, {23'd0, 1'b1, 8'h5A});
        idle(1'b0);
        check("busy_single_pulse", {31'd0, TX_D_VLD}, 32'd0);

        // Read that never gets RdData_Valid.
        rx(8'hBB);
        rx(8'h03);
        check("to_rden", {31'd0, RdEn}, 32'd1);
        k = 0; tv_seen = 1'b0; en_seen = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            idle(1'b0);
            tv_seen = tv_seen | TX_D_VLD;
            en_seen = en_seen | WrEn | RdEn;
            if (Cmd_Err) begin
                k = i;
                break;
            end
        end
        check("to_err_delay", k, TIMEOUT);
        check("to_no_tx_no_en", {30'd0, tv_seen, en_seen}, 32'd0);
        idle(1'b0);
        check("to_err_pulse", {31'd0, Cmd_Err}, 32'd0);

        // Reset in the middle of a write frame.
        rx(8'hAA);
        rx(8'h05);
        check("mid_addr", {28'd0, Address}, 32'h5);
        @(negedge CLK);
        RST_n = 1'b0;
        #1;
        check("mid_reset_async", {8'd0, obs}, 32'd0);
        @(posedge CLK);
        @(posedge CLK);
        #1;
        check("mid_reset_hold", {8'd0, obs}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        rx(8'h3C);
        check("post_reset_byte", {8'd0, obs}, {8'd0, ex(0,0,4'h0,8'h00,8'h00,0,1)});
        idle(1'b0);
        check("post_reset_end", {8'd0, obs}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_cmd_ctrl.md
Name: reg_cmd_ctrl

Overview:
- Command-side master for the register file; the other end of its WrEn/RdEn/Address/WrData/RdData/RdData_Valid interface.
- Takes byte frames from the UART receiver and turns them into single-cycle register-file writes and reads.
- Sends read results back through the UART transmitter's parallel-data handshake.
- Sits in the main system clock domain, between the RX/TX synchronisers and the register file.

Parameters:
- WIDTH, 8, register data width; also the UART byte width.
- DEPTH, 16, register file depth; ADDR_W = $clog2(DEPTH).
- WR_CMD, 8'hAA, opcode for a write frame: opcode, addr, data.
- RD_CMD, 8'hBB, opcode for a read frame: opcode, addr.
- TIMEOUT, 16, max cycles to wait for RdData_Valid after RdEn.

Ports:
- CLK  in  1  system clock.
- RST_n  in  1  asynchronous active-low reset.
- RX_P_DATA  in  WIDTH  received byte.
- RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA is valid.
- RdData  in  WIDTH  register file read data.
- RdData_Valid  in  1  register file read-data strobe.
- TX_Busy  in  1  transmitter busy; a new byte may not be offered while high.
- WrEn  out  1  register file write enable, one-cycle pulse.
- RdEn  out  1  register file read enable, one-cycle pulse.
- Address  out  ADDR_W  register address.
- WrData  out  WIDTH  register write data.
- TX_P_DATA  out  WIDTH  byte to transmit.
- TX_D_VLD  out  1  one-cycle strobe to the transmitter.
- Cmd_Err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Clock and reset: one clock, CLK. RST_n is asynchronous, active-low.
- Reset values: FSM in IDLE; all outputs 0 (WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, Cmd_Err); timeout counter 0.
- Output timing: all outputs are registered. WrEn, RdEn, TX_D_VLD and Cmd_Err are high for exactly one cycle per event.
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_WAIT.
- IDLE:
  - Acts only on RX_D_VLD.
  - Byte == WR_CMD -> WR_ADDR.
  - Byte == RD_CMD -> RD_ADDR.
  - Any other byte -> Cmd_Err pulse next cycle; stay in IDLE.
- WR_ADDR:
  - On RX_D_VLD, latch RX_P_DATA[ADDR_W-1:0] into Address -> WR_DATA.
  - If RX_P_DATA[WIDTH-1:ADDR_W] != 0 -> Cmd_Err pulse; -> IDLE; no write is issued.
- WR_DATA:
  - On RX_D_VLD, WrData <= RX_P_DATA and WrEn = 1 for one cycle -> IDLE.
  - Address and WrData hold their values after the pulse until the next command changes them.
- RD_ADDR:
  - Same address capture and range check as WR_ADDR.
  - Valid address -> RdEn = 1 for one cycle -> RD_WAIT, counter cleared.
- RD_WAIT:
  - On RdData_Valid, TX_P_DATA <= RdData -> TX_WAIT.
  - Otherwise the counter increments. When it reaches TIMEOUT-1 without a valid strobe -> Cmd_Err pulse -> IDLE.
- TX_WAIT:
  - When TX_Busy == 0, TX_D_VLD = 1 for one cycle -> IDLE.
  - While TX_Busy == 1, hold TX_P_DATA and keep waiting; no timeout in this state.
- Latency:
  - RX_D_VLD of the data byte -> WrEn high on the next cycle.
  - RX_D_VLD of the read address byte -> RdEn high on the next cycle.
  - Register file returns RdData_Valid one cycle after RdEn. With TX idle, TX_D_VLD is high 2 cycles after RdData_Valid.
- Boundary conditions:
  - RX_D_VLD arriving in RD_WAIT or TX_WAIT is dropped, with no error.
  - RdData_Valid outside RD_WAIT is ignored.
  - Never assert WrEn and RdEn in the same cycle.
  - Address-only range rule: writes to read-only registers (e.g. 2, 3) are still issued; the register file discards them.
  - Reset mid-frame: everything returns to reset values immediately; the partial frame is discarded.
- Arithmetic: timeout counter width is $clog2(TIMEOUT)+1 and saturates; it never wraps.

Decomposition:
- Shared package (reg_cmd_pkg):
  - FSM state enum.
  - Opcode constants WR_CMD and RD_CMD.
  - Any future opcode constants (ALU, etc.).
- No sub-module needed; the timeout counter stays inline.

Test Plan:
- Write frame: RX bytes AA, 07, 46 -> WrEn one cycle with Address=7, WrData=8'h46; no TX_D_VLD; Cmd_Err=0.
- Read frame: RX bytes BB, 07, with a register-file model returning 46 one cycle after RdEn -> RdEn one cycle with Address=7; TX_P_DATA=8'h46; TX_D_VLD one cycle.
- Read with TX_Busy held high 20 cycles after RdData_Valid -> TX_D_VLD stays 0 until TX_Busy falls, then pulses once with TX_P_DATA=8'h46.
- Bad opcode 8'h55, then bad address AA, 8'h25 -> one Cmd_Err pulse for each; no WrEn or RdEn; FSM back in IDLE, and a following AA, 01, 3C writes correctly.
- Read timeout: BB, 03 with RdData_Valid never asserted -> Cmd_Err pulses TIMEOUT cycles after RdEn; no TX_D_VLD.
- Reset mid-frame: AA, 05, then RST_n low 2 cycles, then 3C -> no WrEn; all outputs 0 during reset; the 3C byte raises Cmd_Err, since it is an unknown opcode in IDLE.
